// File: rtl/sigma_mem_bank_pkg.sv
// sigma_mem_bank_pkg: shared widths, owner state type and lane parity helper for the Sigma memory bank.
package sigma_mem_bank_pkg;
    localparam int SIGMA_WORD_W = 32;
    localparam int SIGMA_ADDR_W = 17;
    localparam int SIGMA_LANES  = 4;

    typedef enum logic {IDLE, LOCKED} own_state_t;

    function automatic logic [SIGMA_LANES-1:0] lane_parity(input logic [SIGMA_WORD_W-1:0] w);
        for (int k = 0; k < SIGMA_LANES; k++) lane_parity[k] = ^w[8*k +: 8];
    endfunction
endpackage

// File: rtl/sigma_rr_arbiter.sv
// sigma_rr_arbiter: round-robin grant with per-port lock ownership for the Sigma memory bank.
module sigma_rr_arbiter
    import sigma_mem_bank_pkg::*;
#(
    parameter int NPORTS = 2,
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] lock,
    output logic [NPORTS-1:0] gnt,
    output logic [PW-1:0]     gidx,
    output logic              gvalid
);
    own_state_t        state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     ptr;
    logic [NPORTS-1:0] gnt_raw;
    logic              found;
    int                idx;

    always_comb begin
        gnt_raw = '0;
        found   = 1'b0;
        gidx    = ptr;
        idx     = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(ptr) + k) % NPORTS;
            if (!found && req[idx]) begin
                gnt_raw[idx] = 1'b1;
                gidx         = PW'(idx);
                found        = 1'b1;
            end
        end
        // A locked owner excludes everyone else until it drops lock.
        if (state == LOCKED) begin
            gnt_raw        = '0;
            gnt_raw[owner] = req[owner];
            gidx           = owner;
            found          = req[owner];
        end
    end

    assign gnt    = reset ? '0 : gnt_raw;
    assign gvalid = found && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= PW'(NPORTS - 1);
        end else begin
            if (found) ptr <= gidx;
            if (state == IDLE && found && lock[gidx]) begin
                state <= LOCKED;
                owner <= gidx;
            end else if (state == LOCKED && !lock[owner]) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: rtl/sigma_mem_bank.sv
// sigma_mem_bank: multi-requester Sigma main-memory bank, 1-cycle read latency, byte-lane writes.
// Optional per-lane even parity storage and checking when MEM_PARITY_EN is defined.
module sigma_mem_bank
    import sigma_mem_bank_pkg::*;
#(
    parameter int NPORTS    = 2,
    parameter int ADDR_BITS = 10,
    parameter     INIT_FILE = "",
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NPORTS-1:0]                req,
    input  logic [NPORTS-1:0]                lock,
    input  logic [SIGMA_LANES*NPORTS-1:0]    we,
    input  logic [SIGMA_ADDR_W*NPORTS-1:0]   addr,
    input  logic [SIGMA_WORD_W*NPORTS-1:0]   wdata,
    output logic [NPORTS-1:0]                gnt,
    output logic [NPORTS-1:0]                rvalid,
    output logic [SIGMA_WORD_W-1:0]          rdata,
    output logic                             perr
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [PW-1:0]           gidx;
    logic                    gvalid;
    logic [SIGMA_LANES-1:0]  w_sel;
    logic [SIGMA_ADDR_W-1:0] a_sel;
    logic [SIGMA_WORD_W-1:0] d_sel;
    logic [ADDR_BITS-1:0]    idx;
    logic [SIGMA_WORD_W-1:0] mem [DEPTH];

    sigma_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .gnt    (gnt),
        .gidx   (gidx),
        .gvalid (gvalid)
    );

    assign w_sel = we[SIGMA_LANES*gidx +: SIGMA_LANES];
    assign a_sel = addr[SIGMA_ADDR_W*gidx +: SIGMA_ADDR_W];
    assign d_sel = wdata[SIGMA_WORD_W*gidx +: SIGMA_WORD_W];
    assign idx   = a_sel[ADDR_BITS-1:0];

`ifdef MEM_PARITY_EN
    logic [SIGMA_LANES-1:0] par [DEPTH];
    logic                   perr_q;
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
`ifdef MEM_PARITY_EN
        for (int i = 0; i < DEPTH; i++) par[i] = lane_parity(mem[i]);
`endif
    end

    // The array has no reset; an edge with reset high must not write.
    always_ff @(posedge clock) begin
        if (!reset && gvalid) begin
            for (int k = 0; k < SIGMA_LANES; k++) begin
                if (w_sel[k]) begin
                    mem[idx][8*k +: 8] <= d_sel[8*k +: 8];
`ifdef MEM_PARITY_EN
                    par[idx][k] <= ^d_sel[8*k +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid <= '0;
            rdata  <= '0;
`ifdef MEM_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            rvalid <= gnt;
            if (gvalid) begin
                rdata <= mem[idx];
`ifdef MEM_PARITY_EN
                perr_q <= |(par[idx] ^ lane_parity(mem[idx]));
`endif
            end
        end
    end
endmodule

// File: tb/tb_sigma_mem_bank.sv
// tb_sigma_mem_bank: directed checks of arbitration, locking, lane writes, wrap and reset for sigma_mem_bank.
module tb_sigma_mem_bank;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0, lock = '0, gnt, rvalid;
    logic [7:0]  we = '0;
    logic [33:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [31:0] rdata;
    logic        perr;
    int          n_cmp = 0, n_bad = 0;

    sigma_mem_bank dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .perr   (perr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int p, input logic r, input logic l, input logic [3:0] w,
                       input logic [16:0] a, input logic [31:0] d);
        req[p] = r;
        lock[p] = l;
        we[4*p +: 4] = w;
        addr[17*p +: 17] = a;
        wdata[32*p +: 32] = d;
    endtask

    initial begin
        step();
        drv(0, 1, 0, 4'hF, 17'h040, 32'h12345678);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_perr", perr, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("t1_wr_gnt", gnt, 2'b01);
        step();
        chk("t1_wr_rvalid", rvalid, 2'b01);
        chk("t1_wr_rdata_old", rdata, 32'h0);
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        #1;
        chk("t1_rd_gnt", gnt, 2'b01);
        step();
        chk("t1_rd_rvalid", rvalid, 2'b01);
        chk("t1_rd_rdata", rdata, 32'h12345678);
        drv(0, 1, 0, 4'h2, 17'h040, 32'hFFFFAAFF);
        step();
        chk("t2_lane_wr_old", rdata, 32'h12345678);
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        step();
        chk("t2_lane_rd", rdata, 32'h1234AA78);
        chk("t2_perr", perr, 1'b0);
        drv(0, 0, 0, 4'h0, 17'h040, 32'h0);
        step();
        chk("idle_rvalid", rvalid, 2'b00);
        chk("idle_rdata_hold", rdata, 32'h1234AA78);
        drv(1, 1, 0, 4'hF, 17'h041, 32'hCAFEF00D);
        #1;
        chk("p1_wr_gnt", gnt, 2'b10);
        step();
        chk("p1_wr_rvalid", rvalid, 2'b10);
        drv(1, 1, 0, 4'h0, 17'h041, 32'h0);
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_rr_gnt", gnt, (i % 2) ? 2'b10 : 2'b01);
            step();
            chk("t3_rr_rvalid", rvalid, (i % 2) ? 2'b10 : 2'b01);
            chk("t3_rr_rdata", rdata, (i % 2) ? 32'hCAFEF00D : 32'h1234AA78);
        end
        drv(0, 0, 0, 4'h0, 17'h040, 32'h0);
        drv(1, 1, 1, 4'h0, 17'h041, 32'h0);
        #1;
        chk("t4_lock_gnt", gnt, 2'b10);
        step();
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_locked_gnt", gnt, 2'b10);
            step();
            chk("t4_locked_rvalid", rvalid, 2'b10);
        end
        drv(1, 0, 0, 4'h0, 17'h041, 32'h0);
        #1;
        chk("t4_release_gnt", gnt, 2'b00);
        step();
        chk("t4_release_rvalid", rvalid, 2'b00);
        #1;
        chk("t4_after_gnt", gnt, 2'b01);
        step();
        chk("t4_after_rvalid", rvalid, 2'b01);
        chk("t4_after_rdata", rdata, 32'h1234AA78);
        drv(0, 1, 0, 4'hF, 17'h00401, 32'hDEADBEEF);
        step();
        drv(0, 1, 0, 4'h0, 17'h00001, 32'h0);
        step();
        chk("t5_wrap_rdata", rdata, 32'hDEADBEEF);
        drv(0, 1, 0, 4'h0, 17'h10401, 32'h0);
        step();
        chk("t5_wrap_hi_rdata", rdata, 32'hDEADBEEF);
        drv(0, 0, 0, 4'h0, 17'h0, 32'h0);
        drv(1, 1, 1, 4'h0, 17'h041, 32'h0);
        #1;
        chk("t6_lock_gnt", gnt, 2'b10);
        step();
        drv(1, 1, 1, 4'hF, 17'h050, 32'h11111111);
        #1;
        chk("t6_locked_gnt", gnt, 2'b10);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_rvalid", rvalid, 2'b00);
        step();
        chk("t6_rst_edge_rvalid", rvalid, 2'b00);
        reset = 1'b0;
        drv(1, 0, 0, 4'h0, 17'h0, 32'h0);
        drv(0, 1, 0, 4'h0, 17'h050, 32'h0);
        #1;
        chk("t6_unlocked_gnt", gnt, 2'b01);
        step();
        chk("t6_nowrite_rvalid", rvalid, 2'b01);
        chk("t6_nowrite_rdata", rdata, 32'h0);
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        step();
        chk("t6_persist_rdata", rdata, 32'h1234AA78);
        chk("t6_perr", perr, 1'b0);
`ifdef MEM_PARITY_EN
        drv(0, 1, 0, 4'hF, 17'h010, 32'hA5A5A5A5);
        step();
        dut.mem[16][0] = ~dut.mem[16][0];
        drv(0, 1, 0, 4'h0, 17'h010, 32'h0);
        step();
        chk("par_bad_rvalid", rvalid, 2'b01);
        chk("par_bad_perr", perr, 1'b1);
        drv(0, 1, 0, 4'h0, 17'h040, 32'h0);
        step();
        chk("par_clean_perr", perr, 1'b0);
`endif
        drv(0, 0, 0, 4'h0, 17'h0, 32'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
